reg_file: RTL

Architectural integer register file of the RV32I pipeline. It is the consumer end of the Write Back path: it accepts the selected write-back word, destination index and write strobe, and serves two combinational read ports to the Decode stage. Same-cycle write-to-read bypass removes the WB→ID structural hazard. A committed-write counter supports bench and debug visibility.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_if.sv | 34 +++
 rtl/reg_file_read_port.sv | 36 +++
 rtl/reg_file.sv | 85 ++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants for the RV32I integer register file.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Holds the default data width, register count, index width, the
// architectural names of x0/x2 and the default stack-pointer reset value.
package reg_file_pkg;

  localparam int              DEF_XLEN    = 32;
  localparam int              DEF_NREGS   = 32;
  localparam int              REG_ADDR_W  = 5;
  localparam logic [4:0]      REG_ZERO    = 5'd0;
  localparam logic [4:0]      REG_SP      = 5'd2;
  localparam logic [31:0]     DEF_SP_INIT = 32'h0000_0000;

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: write-back strobe/data plus two decode read ports and the
// committed-write counter, bundled between the pipeline and the register file.
// Latency: n/a (wires only). Backpressure: none, no handshake on this bus.
//
// master (pipeline): drives reg_write, rd_addr, write_data, rs1_addr, rs2_addr;
//                    receives rs1_data, rs2_data, wr_count.
// slave  (reg_file): the mirror image.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = REG_ADDR_W
);

  logic            reg_write;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] write_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [31:0]     wr_count;

  modport master (
    output reg_write, rd_addr, write_data, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wr_count
  );

  modport slave (
    input  reg_write, rd_addr, write_data, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wr_count
  );

endinterface

// File: rtl/reg_file_read_port.sv
// reg_read_port: one combinational read port with x0 forcing and WB bypass.
// Latency: 0 cycles (pure combinational select).
// Backpressure: none.
//
// Ports: regs (x1..x(NREGS-1) storage), rs_addr (read index),
//        reg_write/rd_addr/write_data (current WB write, for bypass),
//        rs_data (selected word).
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = REG_ADDR_W
) (
  input  logic [NREGS-1:1][XLEN-1:0] regs,
  input  logic [AW-1:0]              rs_addr,
  input  logic                       reg_write,
  input  logic [AW-1:0]              rd_addr,
  input  logic [XLEN-1:0]            write_data,
  output logic [XLEN-1:0]            rs_data
);

  // x0 is checked first so a discarded write to x0 can never leak through
  // the bypass path.
  always_comb begin
    rs_data = '0;
    if (rs_addr == REG_ZERO) begin
      rs_data = '0;
    end else if (reg_write && (rd_addr == rs_addr)) begin
      rs_data = write_data;
    end else begin
      rs_data = regs[rs_addr];
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: RV32I architectural register file, end of the write-back path.
// Latency: write 1 cycle into storage (0 via bypass), reads 0 cycles.
// Backpressure: none; producer holds reg_write low on WB bubbles.
//
// Ports: clk, rst (sync, active high), bus (reg_file_if.slave) carrying the
//        write strobe/index/data, two read indices, two read data words and
//        the committed-write counter.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int              XLEN    = DEF_XLEN,
  parameter int              NREGS   = DEF_NREGS,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(DEF_SP_INIT)
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  // x0 has no storage; entries start at index 1.
  logic [NREGS-1:1][XLEN-1:0] regs_q, regs_d;
  logic [31:0]                wr_count_q, wr_count_d;
  logic                       wr_commit;

  assign wr_commit = bus.reg_write && (bus.rd_addr != REG_ZERO);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_commit) begin
      for (int i = 1; i < NREGS; i++) begin
        if (bus.rd_addr == AW'(i)) begin
          regs_d[i] = bus.write_data;
        end
      end
      // Free-running: wraps to 0 after all-ones.
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  // Reset wins over a simultaneous write; that write is neither stored nor
  // counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= (AW'(i) == REG_SP) ? SP_INIT : '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.wr_count = wr_count_q;

  reg_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rs1_port (
    .regs       (regs_q),
    .rs_addr    (bus.rs1_addr),
    .reg_write  (bus.reg_write),
    .rd_addr    (bus.rd_addr),
    .write_data (bus.write_data),
    .rs_data    (bus.rs1_data)
  );

  reg_read_port #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rs2_port (
    .regs       (regs_q),
    .rs_addr    (bus.rs2_addr),
    .reg_write  (bus.reg_write),
    .rd_addr    (bus.rd_addr),
    .write_data (bus.write_data),
    .rs_data    (bus.rs2_data)
  );

endmodule
